// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmit scheduler: state encoding and default frame width.
package usart_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/usart_rr_arbiter.sv
// Combinational round-robin pick: first requester found at ptr+1, ptr+2, ... (mod N).
module usart_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);

  int unsigned c;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/usart_tx_scheduler.sv
// Shares one USART transmitter between N_CLIENTS requesters: round-robin grant,
// config latching, UDR load pulse, start timeout and per-client ack/done pulses.
module usart_tx_scheduler
  import usart_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned START_TMO = 16
) (
  input  logic                          i_txclk,
  input  logic                          i_rst,
  input  logic [N_CLIENTS-1:0]          i_req,
  input  logic [N_CLIENTS*DATA_W-1:0]   i_data,
  input  logic [N_CLIENTS-1:0]          i_upm1,
  input  logic [N_CLIENTS-1:0]          i_usbs,
  input  logic                          i_transmit_complete,
  input  logic                          i_clr_err,
  output logic                          o_data_in_udr,
  output logic [DATA_W-1:0]             o_tx_data,
  output logic                          o_tx_upm1,
  output logic                          o_tx_usbs,
  output logic [N_CLIENTS-1:0]          o_ack,
  output logic [N_CLIENTS-1:0]          o_done,
  output logic [$clog2(N_CLIENTS)-1:0]  o_grant_id,
  output logic                          o_busy,
  output logic                          o_timeout_err
);

  localparam int unsigned IW = $clog2(N_CLIENTS);
  localparam int unsigned CW = $clog2(START_TMO) + 1;

  tx_state_e              state, state_next;
  logic [IW-1:0]          ptr;
  logic [N_CLIENTS-1:0]   grant_oh;
  logic [N_CLIENTS-1:0]   arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_valid;
  logic [CW-1:0]          cnt;
  logic                   grant_en;
  logic                   tmo_hit;

  usart_rr_arbiter #(.N(N_CLIENTS)) u_arb (
    .req   (i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge i_txclk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    grant_en      = 1'b0;
    tmo_hit       = 1'b0;
    o_data_in_udr = 1'b0;
    o_ack         = '0;
    o_done        = '0;
    o_busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        // A low transmit_complete means the transmitter is owned elsewhere.
        if (arb_valid && i_transmit_complete) begin
          grant_en   = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_data_in_udr = 1'b1;
        o_ack         = grant_oh;
        state_next    = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!i_transmit_complete) begin
          state_next = ST_WAIT_DONE;
        end else if (cnt == CW'(START_TMO - 1)) begin
          tmo_hit    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_transmit_complete) begin
          o_done     = grant_oh;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latched config stays valid until the next grant; the tx FSM samples it mid-frame.
  always_ff @(posedge i_txclk) begin
    if (i_rst) begin
      ptr           <= IW'(N_CLIENTS - 1);
      grant_oh      <= '0;
      o_tx_data     <= '0;
      o_tx_upm1     <= 1'b0;
      o_tx_usbs     <= 1'b0;
      o_grant_id    <= '0;
      cnt           <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      if (grant_en) begin
        ptr        <= arb_idx;
        grant_oh   <= arb_grant;
        o_tx_data  <= i_data[arb_idx*DATA_W +: DATA_W];
        o_tx_upm1  <= i_upm1[arb_idx];
        o_tx_usbs  <= i_usbs[arb_idx];
        o_grant_id <= arb_idx;
      end
      if (state == ST_LOAD)
        cnt <= '0;
      else if (state == ST_WAIT_START && i_transmit_complete)
        cnt <= cnt + 1'b1;
      if (tmo_hit)
        o_timeout_err <= 1'b1;
      else if (i_clr_err)
        o_timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usart_tx_scheduler.sv
// Directed + randomized bench for usart_tx_scheduler with a transaction-level reference model.
module tb_usart_tx_scheduler;

  logic        i_txclk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  i_upm1;
  logic [3:0]  i_usbs;
  logic        i_transmit_complete;
  logic        i_clr_err;
  logic        o_data_in_udr;
  logic [7:0]  o_tx_data;
  logic        o_tx_upm1;
  logic        o_tx_usbs;
  logic [3:0]  o_ack;
  logic [3:0]  o_done;
  logic [1:0]  o_grant_id;
  logic        o_busy;
  logic        o_timeout_err;

  int total = 0;
  int bad   = 0;
  int mptr  = 3;

  usart_tx_scheduler #(.N_CLIENTS(4), .DATA_W(8), .START_TMO(16)) dut (
    .i_txclk             (i_txclk),
    .i_rst               (i_rst),
    .i_req               (i_req),
    .i_data              (i_data),
    .i_upm1              (i_upm1),
    .i_usbs              (i_usbs),
    .i_transmit_complete (i_transmit_complete),
    .i_clr_err           (i_clr_err),
    .o_data_in_udr       (o_data_in_udr),
    .o_tx_data           (o_tx_data),
    .o_tx_upm1           (o_tx_upm1),
    .o_tx_usbs           (o_tx_usbs),
    .o_ack               (o_ack),
    .o_done              (o_done),
    .o_grant_id          (o_grant_id),
    .o_busy              (o_busy),
    .o_timeout_err       (o_timeout_err)
  );

  always #5 i_txclk = ~i_txclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge i_txclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester scanning upward from the last winner.
  function automatic int pick(input logic [3:0] r);
    for (int i = 1; i <= 4; i++)
      if (r[(mptr + i) % 4]) return (mptr + i) % 4;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_udr"},  32'(o_data_in_udr), 0);
    chk({tag, "_data"}, 32'(o_tx_data), 0);
    chk({tag, "_upm"},  32'(o_tx_upm1), 0);
    chk({tag, "_usbs"}, 32'(o_tx_usbs), 0);
    chk({tag, "_ack"},  32'(o_ack), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_gid"},  32'(o_grant_id), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_err"},  32'(o_timeout_err), 0);
  endtask

  // One complete frame: grant, load, tx busy for 1+busy cycles, done.
  task automatic run_frame(input logic [3:0] req, input logic [31:0] data,
                           input logic [3:0] upm, input logic [3:0] usbs,
                           input int busy, input bit hold, input logic [3:0] pulse,
                           output int w);
    logic [7:0] ed;
    w  = pick(req);
    ed = data[w*8 +: 8];
    i_req = req; i_data = data; i_upm1 = upm; i_usbs = usbs;
    i_transmit_complete = 1'b1;
    step();
    chk("load_pulse", 32'(o_data_in_udr), 1);
    chk("ack",        32'(o_ack), 32'(1 << w));
    chk("tx_data",    32'(o_tx_data), 32'(ed));
    chk("tx_upm1",    32'(o_tx_upm1), 32'(upm[w]));
    chk("tx_usbs",    32'(o_tx_usbs), 32'(usbs[w]));
    chk("grant_id",   32'(o_grant_id), 32'(w));
    chk("busy_load",  32'(o_busy), 1);
    mptr = w;
    if (!hold) i_req[w] = 1'b0;
    i_data = $urandom;
    i_upm1 = 4'($urandom);
    i_usbs = 4'($urandom);
    step();
    chk("load_1cyc", 32'(o_data_in_udr), 0);
    chk("ack_1cyc",  32'(o_ack), 0);
    i_transmit_complete = 1'b0;
    step();
    for (int k = 0; k < busy; k++) begin
      if (k == 0) i_req = i_req | pulse;
      if (k == 1) i_req = i_req & ~pulse;
      chk("no_early_done", 32'(o_done), 0);
      chk("data_hold",     32'(o_tx_data), 32'(ed));
      step();
    end
    i_req = i_req & ~pulse;
    i_transmit_complete = 1'b1;
    #1;
    chk("done",      32'(o_done), 32'(1 << w));
    chk("busy_done", 32'(o_busy), 1);
    step();
    chk("done_1cyc", 32'(o_done), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("post_data", 32'(o_tx_data), 32'(ed));
    chk("post_gid",  32'(o_grant_id), 32'(w));
  endtask

  // Load with transmit_complete stuck high: 16 WAIT_START cycles then the sticky error.
  task automatic run_timeout(input logic [3:0] req, input bit clr_hold);
    int w;
    w = pick(req);
    i_req = req; i_transmit_complete = 1'b1;
    step();
    chk("tmo_ack", 32'(o_ack), 32'(1 << w));
    mptr = w;
    i_req = '0;
    i_clr_err = clr_hold;
    step();
    for (int k = 0; k < 15; k++) begin
      chk("tmo_wait_busy", 32'(o_busy), 1);
      chk("tmo_wait_err",  32'(o_timeout_err), 0);
      step();
    end
    chk("tmo_last_busy", 32'(o_busy), 1);
    chk("tmo_last_done", 32'(o_done), 0);
    step();
    chk("tmo_err",  32'(o_timeout_err), 1);
    chk("tmo_idle", 32'(o_busy), 0);
    chk("tmo_nodone", 32'(o_done), 0);
    i_clr_err = 1'b0;
  endtask

  initial begin
    int w;
    logic [31:0] d;
    i_rst = 1'b1; i_req = '0; i_data = '0; i_upm1 = '0; i_usbs = '0;
    i_transmit_complete = 1'b1; i_clr_err = 1'b0;
    step(); step();
    i_rst = 1'b0;
    chk_all_zero("reset");

    // Single frame to client 2.
    d = 32'h0000_0000; d[23:16] = 8'hA5;
    run_frame(4'b0100, d, 4'b0100, 4'b0000, 10, 1'b0, 4'b0000, w);

    // Fairness from reset: 0,1,2,3,0 with all requests held.
    i_rst = 1'b1; step(); i_rst = 1'b0; mptr = 3;
    for (int k = 0; k < 5; k++) begin
      run_frame(4'b1111, $urandom, 4'($urandom), 4'($urandom), 1, 1'b1, 4'b0000, w);
      chk("rr_order", 32'(w), 32'(k % 4));
    end

    // Randomized frames.
    for (int k = 0; k < 20; k++)
      run_frame(4'($urandom_range(1, 15)), $urandom, 4'($urandom), 4'($urandom),
                $urandom_range(0, 6), 1'($urandom), 4'b0000, w);

    // Transmitter busy at request time: no load until it is free.
    i_req = 4'b0010; i_transmit_complete = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("txbusy_noload", 32'(o_data_in_udr), 0);
      chk("txbusy_idle",   32'(o_busy), 0);
    end
    run_frame(4'b0010, $urandom, 4'($urandom), 4'($urandom), 3, 1'b0, 4'b0000, w);

    // Start timeout, then clear.
    run_timeout(4'b1000, 1'b0);
    i_clr_err = 1'b1; step(); i_clr_err = 1'b0;
    chk("clr_err", 32'(o_timeout_err), 0);

    // Timeout coinciding with clear: set wins; the flag does not block grants.
    run_timeout(4'b0001, 1'b1);
    run_frame(4'b0100, $urandom, 4'($urandom), 4'($urandom), 2, 1'b0, 4'b0000, w);
    chk("err_sticky", 32'(o_timeout_err), 1);
    i_clr_err = 1'b1; step(); i_clr_err = 1'b0;
    chk("clr_err2", 32'(o_timeout_err), 0);

    // Withdrawn request: req[1] pulsed for one cycle while busy.
    run_frame(4'b1000, $urandom, 4'($urandom), 4'($urandom), 4, 1'b0, 4'b0010, w);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("withdraw_noack",  32'(o_ack), 0);
      chk("withdraw_noload", 32'(o_data_in_udr), 0);
    end

    // Reset during WAIT_DONE aborts the frame; client 0 gets first grant afterwards.
    i_req = 4'b1000; i_transmit_complete = 1'b1;
    step();
    i_req = '0;
    step();
    i_transmit_complete = 1'b0;
    step(); step();
    chk("mid_busy", 32'(o_busy), 1);
    i_rst = 1'b1;
    step();
    chk_all_zero("midreset");
    i_rst = 1'b0; mptr = 3;
    run_frame(4'b1111, $urandom, 4'($urandom), 4'($urandom), 2, 1'b0, 4'b0000, w);
    chk("after_reset_client0", 32'(w), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
